alu_seq_m: RTL and testbench
============================

// Module: alu_seq_m
// PURPOSE
//  Parametrised, handshaked successor to the combinational ALU. Executes RV-I integer
//  ops and branch compares in one cycle, and RV-M multiply/divide/remainder iteratively
//  (radix-2, one bit per cycle). Sits between decode and writeback in the execute stage;
//  decode stalls on in_ready=0.
// PARAMETERS
//  XLEN   32  operand/result width; power of two, >=8
//  SHW    $clog2(XLEN)  shift-amount width (derived; do not override)
// PORTS
//  clk           in   1     rising-edge clock
//  reset         in   1     synchronous, active-high reset
//  in_valid      in   1     operation presented
//  in_ready      out  1     block can accept an operation
//  selector      in   10    {func7,func3}
//  branch        in   1     1: compare op; func3=selector[2:0] selects BEQ/BNE/BLT/BGE/BLTU/BGEU
//  in0, in1      in   XLEN  operands (rs1, rs2/imm)
//  out_valid     out  1     result available
//  out_ready     in   1     consumer takes result
//  out           out  XLEN  result
//  branch_taken  out  1     compare outcome (branch ops only, else 0)
//  illegal       out  1     selector/func3 not supported; out=0
//  busy          out  1     multi-cycle op in progress
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid, out, branch_taken, illegal, busy all 0.
//    Reset mid-operation abandons the op; no result is produced.
//  - States: IDLE -> (accept single-cycle op) DONE; IDLE -> (accept mul/div) BUSY;
//    BUSY -> (counter hits XLEN) DONE; DONE -> (out_ready) IDLE.
//  - Accept = in_valid & in_ready; in_ready = (state==IDLE). Operands, selector and
//    branch are captured at accept; later input changes are ignored.
//  - Latency: single-cycle op accepted at edge N -> out_valid=1 after edge N+1.
//    Mul/div: out_valid=1 after edge N+XLEN+1. busy=1 exactly in BUSY.
//  - Outputs registered; held stable while out_valid & !out_ready. No new accept
//    until the result is consumed (one op in flight).
//  - Ops (selector): ADD 0000000000, SUB 0100000000, SLL 0000000001, SLT 0000000010,
//    SLTU 0000000011, XOR 0000000100, SRL 0000000101, SRA 0100000101, OR 0000000110,
//    AND 0000000111; MUL/MULH/MULHSU/MULHU 0000001000..011;
//    DIV/DIVU/REM/REMU 0000001100..111.
//  - Shifts use in1[SHW-1:0]; SRA sign-fills. SLT/SLTU give 0 or 1 zero-extended.
//  - Arithmetic wraps modulo 2^XLEN; no carry/overflow outputs.
//  - MUL returns low XLEN bits of the 2*XLEN product; MULH* the high XLEN bits, with
//    signed/unsigned operand treatment per RV-M. Signs applied by negating operands before
//    iteration and the product after iteration.
//  - Divide by zero (1-cycle fast path): DIV/DIVU -> all-ones; REM/REMU -> in0.
//  - Signed overflow (in0=most-negative, in1=-1, 1-cycle fast path): DIV -> in0; REM -> 0.
//  - Remainder sign follows dividend; quotient truncates toward zero.
//  - branch=1: selector[9:3] ignored; out=0; branch_taken per func3 (signed for BLT/BGE).
//    func3 010/011 -> illegal=1, branch_taken=0.
//  - Unsupported selector with branch=0: illegal=1, out=0, 1-cycle latency.
// TESTING
//  1 reset held 2 cycles, then in_valid with ADD 7+5 -> out=12 one cycle after accept;
//    stall out_ready=0 for 3 cycles -> out and out_valid held, in_ready=0.
//  2 SRA in0=32'h80000000, in1=4 -> 32'hF8000000; SLT -1,1 -> 1; SLTU -1,1 -> 0.
//  3 MULHU FFFFFFFF*FFFFFFFF -> FFFFFFFE at accept+33; MUL -3*7 -> FFFFFFEB; busy high 32 cycles.
//  4 DIV -7/2 -> FFFFFFFD, REM -> FFFFFFFF; DIVU x/0 -> FFFFFFFF; DIV 80000000/-1 -> 80000000,
//    both edge cases 1-cycle.
//  5 branch=1 BLT in0=-1,in1=0 -> taken=1; BLTU same operands -> 0; func3=010 -> illegal=1.
//  6 reset asserted mid-DIV (cycle 10 of 32) -> next cycle IDLE, out_valid=0, no stale result later.

Source files
------------

// File: rtl/alu_seq_m.sv
// Handshaked execute-stage ALU: RV-I ops and branch compares in one cycle,
// RV-M multiply/divide iterated one bit per cycle on operand magnitudes.
//
// state  | meaning
// IDLE   | ready for a new operation
// EXEC   | operation captured; single-cycle result or mul/div setup
// BUSY   | one multiply/divide bit per cycle, XLEN cycles
// DONE   | result held until the consumer takes it
module alu_seq_m #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [9:0]      selector,
    input  logic            branch,
    input  logic [XLEN-1:0] in0,
    input  logic [XLEN-1:0] in1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            branch_taken,
    output logic            illegal,
    output logic            busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state;
    logic [9:0]      sel_q;
    logic            branch_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic            neg_q;
    logic [SHW-1:0]  cnt;

    logic [6:0] f7;
    logic [2:0] f3;
    logic       is_m;
    logic       is_div;
    logic [SHW-1:0] sh;

    assign f7     = sel_q[9:3];
    assign f3     = sel_q[2:0];
    assign is_m   = !branch_q && (f7 == 7'b0000001);
    assign is_div = is_m && f3[2];
    assign sh     = b_q[SHW-1:0];

    // Single-cycle ops and branch compares
    logic [XLEN-1:0] alu_res;
    logic            alu_ill;
    logic            br_tk;
    logic            lt_s;
    logic            lt_u;

    assign lt_s = $signed(a_q) < $signed(b_q);
    assign lt_u = a_q < b_q;

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        br_tk   = 1'b0;
        if (branch_q) begin
            case (f3)
                3'b000:  br_tk = (a_q == b_q);
                3'b001:  br_tk = (a_q != b_q);
                3'b100:  br_tk = lt_s;
                3'b101:  br_tk = !lt_s;
                3'b110:  br_tk = lt_u;
                3'b111:  br_tk = !lt_u;
                default: alu_ill = 1'b1;
            endcase
        end else begin
            case (f7)
                7'b0000000: begin
                    case (f3)
                        3'b000:  alu_res = a_q + b_q;
                        3'b001:  alu_res = a_q << sh;
                        3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
                        3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
                        3'b100:  alu_res = a_q ^ b_q;
                        3'b101:  alu_res = a_q >> sh;
                        3'b110:  alu_res = a_q | b_q;
                        default: alu_res = a_q & b_q;
                    endcase
                end
                7'b0100000: begin
                    case (f3)
                        3'b000:  alu_res = a_q - b_q;
                        3'b101:  alu_res = $unsigned($signed(a_q) >>> sh);
                        default: alu_ill = 1'b1;
                    endcase
                end
                7'b0000001: alu_ill = 1'b0;
                default:    alu_ill = 1'b1;
            endcase
        end
    end

    // Operand sign handling and the divide fast paths
    logic            signed_a;
    logic            signed_b;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] fast_res;

    assign signed_a = is_div ? !f3[0] : (f3 != 3'b011);
    assign signed_b = is_div ? !f3[0] : !f3[1];
    assign a_neg    = signed_a && a_q[XLEN-1];
    assign b_neg    = signed_b && b_q[XLEN-1];
    assign a_mag    = a_neg ? -a_q : a_q;
    assign b_mag    = b_neg ? -b_q : b_q;
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !f3[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

    always_comb begin
        if (div_zero) fast_res = f3[1] ? a_q : '1;
        else          fast_res = f3[1] ? '0 : a_q;
    end

    // One radix-2 step: shift-add multiply or restoring divide
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fin_res;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    // Partial remainder stays below twice the divisor, so bit XLEN is a clean borrow
    assign div_ge    = !div_diff[XLEN];

    always_comb begin
        if (is_div) begin
            step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
        end
    end

    assign prod_s  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    assign div_val = f3[1] ? step_hi : step_lo;

    always_comb begin
        if (is_div)             fin_res = neg_q ? -div_val : div_val;
        else if (f3 == 3'b000)  fin_res = prod_s[XLEN-1:0];
        else                    fin_res = prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out          <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            busy         <= 1'b0;
            sel_q        <= '0;
            branch_q     <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            acc_hi       <= '0;
            acc_lo       <= '0;
            opnd         <= '0;
            neg_q        <= 1'b0;
            cnt          <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sel_q    <= selector;
                        branch_q <= branch;
                        a_q      <= in0;
                        b_q      <= in1;
                        in_ready <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_m && !div_zero && !div_ovf) begin
                        acc_hi <= '0;
                        acc_lo <= is_div ? a_mag : b_mag;
                        opnd   <= is_div ? b_mag : a_mag;
                        neg_q  <= (is_div && f3[1]) ? a_neg : (a_neg ^ b_neg);
                        cnt    <= SHW'(XLEN - 1);
                        busy   <= 1'b1;
                        state  <= S_BUSY;
                    end else begin
                        out          <= is_m ? fast_res : alu_res;
                        illegal      <= alu_ill;
                        branch_taken <= br_tk;
                        out_valid    <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_BUSY: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        out       <= fin_res;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        out          <= '0;
                        branch_taken <= 1'b0;
                        illegal      <= 1'b0;
                        in_ready     <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_m.sv
// Bench for alu_seq_m (XLEN=32): directed vector table, hand-written
// stall/reset sequences, and random ops against a 64-bit arithmetic model.
module tb_alu_seq_m;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  selector;
    logic        branch;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        branch_taken;
    logic        illegal;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_seq_m #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .selector(selector), .branch(branch), .in0(in0), .in1(in1),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .branch_taken(branch_taken), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: {illegal, taken, result} from plain 64-bit arithmetic
    function automatic logic [33:0] ref_model(input logic [9:0] s, input logic br,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        tk;
        logic        ill;
        longint      sa;
        longint      sb;
        logic [63:0] p;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        f3  = s[2:0];
        f7  = s[9:3];
        r   = 32'd0;
        tk  = 1'b0;
        ill = 1'b0;
        p   = 64'd0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (br) begin
            case (f3)
                3'd0: tk = (a == b);
                3'd1: tk = (a != b);
                3'd4: tk = (sa < sb);
                3'd5: tk = (sa >= sb);
                3'd6: tk = (a < b);
                3'd7: tk = (a >= b);
                default: ill = 1'b1;
            endcase
        end else if (f7 == 7'd0) begin
            case (f3)
                3'd0: r = a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (f7 == 7'd32) begin
            if (f3 == 3'd0)      r = a - b;
            else if (f3 == 3'd5) r = 32'(sa >>> b[4:0]);
            else                 ill = 1'b1;
        end else if (f7 == 7'd1) begin
            case (f3)
                3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
                3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
                3'd2: begin p = 64'(sa * longint'({32'd0, b})); r = p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
                3'd4: r = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
                3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: r = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
                default: r = (b == 0) ? a : a % b;
            endcase
        end else begin
            ill = 1'b1;
        end
        return {ill, tk, r};
    endfunction

    // Multiply and non-degenerate divides iterate; everything else is one cycle
    function automatic logic iterates(input logic [9:0] s, input logic br,
                                      input logic [31:0] a, input logic [31:0] b);
        logic is_m;
        logic fast;
        is_m = !br && (s[9:3] == 7'd1);
        fast = s[2] && ((b == 32'd0) ||
                        (!s[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return is_m && !fast;
    endfunction

    task automatic run_op(input string tag, input logic [9:0] s, input logic br,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_out, input logic e_tk, input logic e_ill);
        int w;
        int lat;
        int bcnt;
        logic it;
        it = iterates(s, br, a, b);
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        selector = s;
        branch   = br;
        in0      = a;
        in1      = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        selector = 10'($urandom);
        branch   = 1'($urandom);
        in0      = $urandom;
        in1      = $urandom;
        lat  = 0;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, lat, it ? 32'd33 : 32'd1);
        chk({tag, " out"}, out, e_out);
        chk({tag, " taken"}, {31'd0, branch_taken}, {31'd0, e_tk});
        chk({tag, " illegal"}, {31'd0, illegal}, {31'd0, e_ill});
        if (it) chk({tag, " busy_cycles"}, bcnt, 32'd32);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [9:0]  sel;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e_out;
        logic        e_tk;
        logic        e_ill;
    } vec_t;

    vec_t tbl[$];

    logic [9:0] legal_ops[18] = '{
        10'b0000000000, 10'b0100000000, 10'b0000000001, 10'b0000000010,
        10'b0000000011, 10'b0000000100, 10'b0000000101, 10'b0100000101,
        10'b0000000110, 10'b0000000111, 10'b0000001000, 10'b0000001001,
        10'b0000001010, 10'b0000001011, 10'b0000001100, 10'b0000001101,
        10'b0000001110, 10'b0000001111
    };

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int stale;
        logic [33:0] e;
        logic [9:0]  s;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        selector  = '0;
        branch    = 1'b0;
        in0       = '0;
        in1       = '0;

        @(negedge clk);
        @(negedge clk);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out", out, 32'd0);
        chk("reset flags", {29'd0, branch_taken, illegal, busy}, 32'd0);
        reset = 1'b0;

        // ADD with a stalled consumer; competing in_valid must not be accepted
        selector = 10'b0000000000; branch = 1'b0; in0 = 32'd7; in1 = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("add valid", {31'd0, out_valid}, 32'd1);
        chk("add out", out, 32'd12);
        selector = 10'b0100000000; in0 = 32'd100; in1 = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall out", out, 32'd12);
            chk("stall valid", {31'd0, out_valid}, 32'd1);
            chk("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consumed valid", {31'd0, out_valid}, 32'd0);
        chk("consumed in_ready", {31'd0, in_ready}, 32'd1);

        tbl.push_back('{"sra",    10'b0100000101, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0});
        tbl.push_back('{"slt",    10'b0000000010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{"sltu",   10'b0000000011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0});
        tbl.push_back('{"sub",    10'b0100000000, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0});
        tbl.push_back('{"sll",    10'b0000000001, 1'b0, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{"srl",    10'b0000000101, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0});
        tbl.push_back('{"mulhu",  10'b0000001011, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0});
        tbl.push_back('{"mul",    10'b0000001000, 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, 1'b0});
        tbl.push_back('{"mulh",   10'b0000001001, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
        tbl.push_back('{"mulhsu", 10'b0000001010, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{"div",    10'b0000001100, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 1'b0});
        tbl.push_back('{"rem",    10'b0000001110, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{"div neg divisor", 10'b0000001100, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 1'b0});
        tbl.push_back('{"rem neg divisor", 10'b0000001110, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0});
        tbl.push_back('{"divu by 0", 10'b0000001101, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0});
        tbl.push_back('{"remu by 0", 10'b0000001111, 1'b0, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0});
        tbl.push_back('{"div ovf", 10'b0000001100, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0});
        tbl.push_back('{"rem ovf", 10'b0000001110, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0});
        tbl.push_back('{"blt",    10'b1111111100, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0});
        tbl.push_back('{"bltu",   10'b0000000110, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0});
        tbl.push_back('{"branch f3=010", 10'b0000000010, 1'b1, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1});
        tbl.push_back('{"illegal alu", 10'b0100000001, 1'b0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b1});

        foreach (tbl[i])
            run_op(tbl[i].name, tbl[i].sel, tbl[i].br, tbl[i].a, tbl[i].b,
                   tbl[i].e_out, tbl[i].e_tk, tbl[i].e_ill);

        // Reset partway through a divide: op abandoned, no result appears later
        selector = 10'b0000001100; branch = 1'b0; in0 = 32'd1000; in1 = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid-div busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("post-reset busy", {31'd0, busy}, 32'd0);
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) stale++;
        end
        chk("no stale result", stale, 32'd0);

        for (int n = 0; n < 220; n++) begin
            br = ($urandom_range(0, 4) == 0);
            if (br || $urandom_range(0, 9) == 0) s = 10'($urandom);
            else                                 s = legal_ops[$urandom_range(0, 17)];
            a = rand_operand();
            b = rand_operand();
            e = ref_model(s, br, a, b);
            run_op($sformatf("rand%0d sel=%b br=%0b a=%h b=%h", n, s, br, a, b),
                   s, br, a, b, e[31:0], e[32], e[33]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
